pclk_edge_detector_mc: RTL and testbench

//   Multi-channel, parametrised successor to the single-channel pixel-clock edge pulser.
//   - Synchronises NCH asynchronous camera strobes (PCLK, VSYNC, HREF, ...) into the clk domain.
//   - Removes glitches with a per-channel stability filter.
//   - Emits a one-clk pulse per accepted edge; the edge type (rise/fall/both/off) is set per channel.
//   - Sits between the camera pins and the capture/framing logic.

---
 rtl/pclk_edge_pkg.sv | 31 +++
 rtl/edge_chan.sv | 155 +++++++++++++++
 rtl/pclk_edge_detector_mc.sv | 56 +++++
 tb/tb_pclk_edge_detector_mc.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pclk_edge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pclk_edge_pkg
// Purpose  : Shared mode encodings, channel filter states and mode decoders
//            for the multi-channel strobe edge detector.
// Revision : 1.0 - initial release
// ============================================================================
package pclk_edge_pkg;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_RISE_PEND = 2'd1,
    ST_HIGH      = 2'd2,
    ST_FALL_PEND = 2'd3
  } chan_state_t;

  function automatic logic rise_enabled(input logic [1:0] m);
    return (m == MODE_RISE) || (m == MODE_BOTH);
  endfunction

  function automatic logic fall_enabled(input logic [1:0] m);
    return (m == MODE_FALL) || (m == MODE_BOTH);
  endfunction

endpackage
`default_nettype wire

// File: rtl/edge_chan.sv
`default_nettype none
// ============================================================================
// Module   : edge_chan
// Purpose  : One strobe channel: synchroniser, glitch filter FSM, edge pulse
//            and, when EDGE_COUNT_EN is defined, a saturating event counter.
// Revision : 1.0 - initial release
// ============================================================================
module edge_chan
  import pclk_edge_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 1
`ifdef EDGE_COUNT_EN
  ,
  parameter int CNT_W       = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic [1:0]       mode,
  output logic             pulse_out,
  output logic             level_out
`ifdef EDGE_COUNT_EN
  ,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] evt_cnt
`endif
);

  localparam int                  c_STAB_W    = $clog2(FILTER_LEN + 1);
  localparam logic [c_STAB_W-1:0] c_STAB_ONE  = c_STAB_W'(1);
  localparam logic [c_STAB_W-1:0] c_STAB_DONE = c_STAB_W'(FILTER_LEN);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;
  chan_state_t            r_state;
  chan_state_t            w_state_nxt;
  logic [c_STAB_W-1:0]    r_stab;
  logic [c_STAB_W-1:0]    w_stab_nxt;
  logic [c_STAB_W-1:0]    w_stab_inc;
  logic                   w_acc_rise;
  logic                   w_acc_fall;
  logic                   w_pulse_nxt;

  assign w_s        = r_sync[SYNC_STAGES-1];
  assign w_stab_inc = r_stab + c_STAB_ONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_stab_nxt  = r_stab;
    w_acc_rise  = 1'b0;
    w_acc_fall  = 1'b0;
    case (r_state)
      ST_LOW: begin
        if (w_s) begin
          if (FILTER_LEN == 1) begin
            w_state_nxt = ST_HIGH;
            w_acc_rise  = 1'b1;
          end else begin
            w_state_nxt = ST_RISE_PEND;
            w_stab_nxt  = c_STAB_ONE;
          end
        end
      end
      ST_RISE_PEND: begin
        if (!w_s) begin
          w_state_nxt = ST_LOW;
          w_stab_nxt  = '0;
        end else if (w_stab_inc == c_STAB_DONE) begin
          w_state_nxt = ST_HIGH;
          w_stab_nxt  = '0;
          w_acc_rise  = 1'b1;
        end else begin
          w_stab_nxt  = w_stab_inc;
        end
      end
      ST_HIGH: begin
        if (!w_s) begin
          if (FILTER_LEN == 1) begin
            w_state_nxt = ST_LOW;
            w_acc_fall  = 1'b1;
          end else begin
            w_state_nxt = ST_FALL_PEND;
            w_stab_nxt  = c_STAB_ONE;
          end
        end
      end
      ST_FALL_PEND: begin
        if (w_s) begin
          w_state_nxt = ST_HIGH;
          w_stab_nxt  = '0;
        end else if (w_stab_inc == c_STAB_DONE) begin
          w_state_nxt = ST_LOW;
          w_stab_nxt  = '0;
          w_acc_fall  = 1'b1;
        end else begin
          w_stab_nxt  = w_stab_inc;
        end
      end
      default: begin
        w_state_nxt = ST_LOW;
        w_stab_nxt  = '0;
      end
    endcase
  end

  // Mode only gates the pulse; the level always tracks accepted edges.
  assign w_pulse_nxt = (w_acc_rise & rise_enabled(mode)) |
                       (w_acc_fall & fall_enabled(mode));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_LOW;
      r_stab    <= '0;
      pulse_out <= 1'b0;
      level_out <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_stab    <= w_stab_nxt;
      pulse_out <= w_pulse_nxt;
      if (w_acc_rise) begin
        level_out <= 1'b1;
      end else if (w_acc_fall) begin
        level_out <= 1'b0;
      end
    end
  end

`ifdef EDGE_COUNT_EN
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (cnt_clr) begin
      r_cnt <= '0;
    end else if (w_pulse_nxt && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign evt_cnt = r_cnt;
`endif

endmodule
`default_nettype wire

// File: rtl/pclk_edge_detector_mc.sv
`default_nettype none
// ============================================================================
// Module   : pclk_edge_detector_mc
// Purpose  : NCH-channel camera strobe synchroniser / glitch filter / edge
//            pulser. Define EDGE_COUNT_EN to add per-channel event counters.
// Revision : 1.0 - initial release
// ============================================================================
module pclk_edge_detector_mc
  import pclk_edge_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 1
`ifdef EDGE_COUNT_EN
  ,
  parameter int CNT_W       = 16
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       sig_in,
  input  logic [2*NCH-1:0]     mode,
  output logic [NCH-1:0]       pulse_out,
  output logic [NCH-1:0]       level_out
`ifdef EDGE_COUNT_EN
  ,
  input  logic                 cnt_clr,
  output logic [NCH*CNT_W-1:0] evt_cnt
`endif
);

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    edge_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN)
`ifdef EDGE_COUNT_EN
      ,
      .CNT_W       (CNT_W)
`endif
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .sig_in    (sig_in[i]),
      .mode      (mode[2*i +: 2]),
      .pulse_out (pulse_out[i]),
      .level_out (level_out[i])
`ifdef EDGE_COUNT_EN
      ,
      .cnt_clr   (cnt_clr),
      .evt_cnt   (evt_cnt[CNT_W*i +: CNT_W])
`endif
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_pclk_edge_detector_mc.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_pclk_edge_detector_mc
// Purpose  : Scoreboard bench; two DUTs (FILTER_LEN 1 and 3) share stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pclk_edge_detector_mc;

  localparam int NCH   = 4;
  localparam int SYNC  = 2;
  localparam int FA    = 1;
  localparam int FB    = 3;
  localparam int CNT_W = 4;
  localparam int MW    = 2 * NCH;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NCH-1:0] sig_in = '0;
  logic [MW-1:0]  mode = '0;
  logic           cnt_clr = 1'b0;
  logic [NCH-1:0] pulse_a, level_a, pulse_b, level_b;
`ifdef EDGE_COUNT_EN
  logic [NCH*CNT_W-1:0] evt_a, evt_b;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pclk_edge_detector_mc #(
    .NCH(NCH), .SYNC_STAGES(SYNC), .FILTER_LEN(FA)
`ifdef EDGE_COUNT_EN
    , .CNT_W(CNT_W)
`endif
  ) dut_a (
    .clk(clk), .rst(rst), .sig_in(sig_in), .mode(mode),
    .pulse_out(pulse_a), .level_out(level_a)
`ifdef EDGE_COUNT_EN
    , .cnt_clr(cnt_clr), .evt_cnt(evt_a)
`endif
  );

  pclk_edge_detector_mc #(
    .NCH(NCH), .SYNC_STAGES(SYNC), .FILTER_LEN(FB)
`ifdef EDGE_COUNT_EN
    , .CNT_W(CNT_W)
`endif
  ) dut_b (
    .clk(clk), .rst(rst), .sig_in(sig_in), .mode(mode),
    .pulse_out(pulse_b), .level_out(level_b)
`ifdef EDGE_COUNT_EN
    , .cnt_clr(cnt_clr), .evt_cnt(evt_b)
`endif
  );

  typedef struct packed {
    logic [NCH-1:0]       pa, la, pb, lb;
    logic [NCH*CNT_W-1:0] ca, cb;
  } exp_t;

  exp_t           exp_q[$];
  logic [NCH-1:0] dl[$];        // input samples still travelling the synchroniser
  bit             m_lvl[2][NCH];
  int             m_run[2][NCH]; // consecutive samples disagreeing with the level
  int             m_cnt[2][NCH];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  // Reference: a level flips once FILTER consecutive synced samples disagree with it.
  always @(posedge clk) begin : model
    exp_t           e;
    logic [NCH-1:0] s;
    logic [1:0]     m;
    bit             p;
    int             filt;
    e = '0;
    if (rst) begin
      dl.delete();
      for (int k = 0; k < SYNC; k++) dl.push_back('0);
      for (int a = 0; a < 2; a++)
        for (int ch = 0; ch < NCH; ch++) begin
          m_lvl[a][ch] = 0; m_run[a][ch] = 0; m_cnt[a][ch] = 0;
        end
    end else begin
      s = dl.pop_front();
      dl.push_back(sig_in);
      for (int a = 0; a < 2; a++) begin
        filt = (a == 0) ? FA : FB;
        for (int ch = 0; ch < NCH; ch++) begin
          m = mode[2*ch +: 2];
          p = 0;
          if (s[ch] != m_lvl[a][ch]) m_run[a][ch]++;
          else m_run[a][ch] = 0;
          if (m_run[a][ch] >= filt) begin
            m_lvl[a][ch] = s[ch];
            m_run[a][ch] = 0;
            p = s[ch] ? (m == 2'b01 || m == 2'b11) : (m == 2'b10 || m == 2'b11);
          end
          if (cnt_clr) m_cnt[a][ch] = 0;
          else if (p && m_cnt[a][ch] < (1 << CNT_W) - 1) m_cnt[a][ch]++;
          if (a == 0) begin
            e.pa[ch] = p; e.la[ch] = m_lvl[a][ch];
            e.ca[ch*CNT_W +: CNT_W] = m_cnt[a][ch][CNT_W-1:0];
          end else begin
            e.pb[ch] = p; e.lb[ch] = m_lvl[a][ch];
            e.cb[ch*CNT_W +: CNT_W] = m_cnt[a][ch][CNT_W-1:0];
          end
        end
      end
    end
    exp_q.push_back(e);
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pulse_a", 64'(pulse_a), 64'(e.pa));
      chk("level_a", 64'(level_a), 64'(e.la));
      chk("pulse_b", 64'(pulse_b), 64'(e.pb));
      chk("level_b", 64'(level_b), 64'(e.lb));
`ifdef EDGE_COUNT_EN
      chk("evt_cnt_a", 64'(evt_a), 64'(e.ca));
      chk("evt_cnt_b", 64'(evt_b), 64'(e.cb));
`endif
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    int div;
    tick(1);
    chk("reset_pulse", 64'({pulse_a, pulse_b}), 64'd0);
    chk("reset_level", 64'({level_a, level_b}), 64'd0);
    tick(2);
    rst = 1'b0;
    // ch3 off, ch2 fall, ch1 both, ch0 rise
    mode = {2'b00, 2'b10, 2'b11, 2'b01};
    tick(3);

    sig_in[0] = 1'b1; tick(8);
    sig_in[0] = 1'b0; tick(8);

    sig_in[1] = 1'b1; tick(2);
    sig_in[1] = 1'b0; tick(8);
    sig_in[1] = 1'b1; tick(5);
    sig_in[1] = 1'b0; tick(10);

    repeat (2) begin
      sig_in[3:2] = 2'b11; tick(6);
      sig_in[3:2] = 2'b00; tick(6);
    end

    sig_in[0] = 1'b1; tick(8);
    rst = 1'b1;
    #1;
    chk("async_rst_level", 64'({level_a, level_b}), 64'd0);
    chk("async_rst_pulse", 64'({pulse_a, pulse_b}), 64'd0);
    tick(2);
    rst = 1'b0;
    tick(10);
    sig_in[0] = 1'b0; tick(8);

    cnt_clr = 1'b1; tick(1);
    cnt_clr = 1'b0;
    repeat (20) begin
      sig_in[0] = 1'b1; tick(4);
      sig_in[0] = 1'b0; tick(4);
    end
`ifdef EDGE_COUNT_EN
    chk("sat_cnt_a", 64'(evt_a[CNT_W-1:0]), 64'd15);
    chk("sat_cnt_b", 64'(evt_b[CNT_W-1:0]), 64'd15);
`endif
    // Clear lands on the same edge as dut_a's rise pulse.
    sig_in[0] = 1'b1; tick(2);
    cnt_clr = 1'b1; tick(1);
    cnt_clr = 1'b0;
`ifdef EDGE_COUNT_EN
    chk("clr_vs_pulse_a", 64'(evt_a[CNT_W-1:0]), 64'd0);
`endif
    tick(6);

    mode[1:0] = 2'b11;
    repeat (12) begin
      sig_in[0] = ~sig_in[0]; tick(1);
    end
    tick(6);

    for (int seg = 0; seg < 20; seg++) begin
      div = $urandom_range(8, 1);
      for (int i = 0; i < 150; i++) begin
        for (int ch = 0; ch < NCH; ch++)
          if ($urandom_range(div - 1, 0) == 0) sig_in[ch] = ~sig_in[ch];
        if ($urandom_range(15, 0) == 0) mode = MW'($urandom);
        cnt_clr = ($urandom_range(63, 0) == 0);
        if ($urandom_range(399, 0) == 0) begin
          rst = 1'b1; tick(2); rst = 1'b0;
        end
        tick(1);
      end
    end
    cnt_clr = 1'b0;
    tick(5);
    chk("scoreboard_drained", 64'(exp_q.size() <= 1), 64'd1);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
